// File: rtl/mul_acc.sv
// mul_acc: accumulates N consecutive unsigned products into one saturated sum
// and presents it on a valid/ready port, stalling the product stream while the
// result waits for the sink.
module mul_acc #(
  parameter int unsigned PW = 16,
  parameter int unsigned AW = 24,
  parameter int unsigned N  = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf
);

  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic [AW:0]   sum_wide;
  logic [AW-1:0] sum_sat;
  logic          sum_ovf;
  logic          beat;
  logic          last_beat;

  // Widened add of the running sum and the incoming product, clamped to all-ones
  always_comb begin
    sum_wide = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, in_prod};
    sum_ovf  = sum_wide[AW];
    sum_sat  = sum_ovf ? '1 : sum_wide[AW-1:0];
  end

  // Next-state decode and handshake qualification
  always_comb begin
    state_nxt = state;
    in_ready  = (state == ACC);
    beat      = in_valid & in_ready;
    last_beat = beat & (cnt == CNT_LAST);
    case (state)
      ACC:     if (last_beat) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // State register; clear returns to accumulation from any state
  always_ff @(posedge clk) begin
    if (!rstn)      state <= ACC;
    else if (clear) state <= ACC;
    else            state <= state_nxt;
  end

  // Accumulator, beat counter, sticky overflow and registered result port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (last_beat) begin
        out_sum   <= sum_sat;
        out_ovf   <= ovf | sum_ovf;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else if (beat) begin
        acc <= sum_sat;
        cnt <= cnt + CW'(1);
        ovf <= ovf | sum_ovf;
      end
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_acc.sv
// tb_mul_acc: directed vectors for mul_acc, run on a 24-bit and a 17-bit
// accumulator instance that share one product stream.
module tb_mul_acc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;

  logic        rdy24, rdy17;
  logic        o24_valid, o17_valid;
  logic [23:0] o24_sum;
  logic [16:0] o17_sum;
  logic        o24_ovf, o17_ovf;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_acc #(.PW(16), .AW(24), .N(4)) u24 (
    .clk(clk), .rstn(rstn), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy24), .in_prod(in_prod),
    .out_valid(o24_valid), .out_ready(out_ready),
    .out_sum(o24_sum), .out_ovf(o24_ovf)
  );

  mul_acc #(.PW(16), .AW(17), .N(4)) u17 (
    .clk(clk), .rstn(rstn), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy17), .in_prod(in_prod),
    .out_valid(o17_valid), .out_ready(out_ready),
    .out_sum(o17_sum), .out_ovf(o17_ovf)
  );

  typedef struct {
    logic [3:0][15:0] p;
    logic [23:0]      s24;
    logic             v24;
    logic [16:0]      s17;
    logic             v17;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was taken
  task automatic send_beat(input logic [15:0] p);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!rdy24 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_timeout", 32'(rdy24), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_group(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++) send_beat(v.p[i]);
    chk({tag, "_valid24"}, 32'(o24_valid), 32'd1);
    chk({tag, "_valid17"}, 32'(o17_valid), 32'd1);
    chk({tag, "_sum24"},   32'(o24_sum),   32'(v.s24));
    chk({tag, "_ovf24"},   32'(o24_ovf),   32'(v.v24));
    chk({tag, "_sum17"},   32'(o17_sum),   32'(v.s17));
    chk({tag, "_ovf17"},   32'(o17_ovf),   32'(v.v17));
    chk({tag, "_inrdy_hold"}, 32'(rdy24),  32'd0);
    if (out_ready) begin
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(o24_valid), 32'd0);
      chk({tag, "_inrdy_back"}, 32'(rdy24),     32'd1);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, d,
                              input logic [23:0] s24, input logic v24,
                              input logic [16:0] s17, input logic v17);
    vec_t v;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.s24 = s24; v.v24 = v24; v.s17 = s17; v.v17 = v17;
    return v;
  endfunction

  vec_t tbl[8];
  logic [15:0] beats[8];

  initial begin
    logic [31:0] q[$];
    logic [31:0] expv;
    int unsigned macc;
    int mcnt, idx, results;
    logic took;

    tbl[0] = mk(16'd3, 16'd5, 16'd7, 16'd9, 24'd24, 1'b0, 17'd24, 1'b0);
    tbl[1] = mk(16'd0, 16'd0, 16'd0, 16'd0, 24'd0, 1'b0, 17'd0, 1'b0);
    tbl[2] = mk(16'd100, 16'd200, 16'd300, 16'd400, 24'd1000, 1'b0, 17'd1000, 1'b0);
    tbl[3] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 24'h3FFFC, 1'b0, 17'h1FFFF, 1'b1);
    tbl[4] = mk(16'd1, 16'd1, 16'd1, 16'd1, 24'd4, 1'b0, 17'd4, 1'b0);
    tbl[5] = mk(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 24'h1FFFF, 1'b0, 17'h1FFFF, 1'b0);
    tbl[6] = mk(16'hFFFF, 16'hFFFF, 16'd2, 16'd0, 24'h20000, 1'b0, 17'h1FFFF, 1'b1);
    tbl[7] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 24'h2FFFD, 1'b0, 17'h1FFFF, 1'b1);
    beats = '{16'd2, 16'd0, 16'd0, 16'd6, 16'd5, 16'd1, 16'd3, 16'd7};

    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_valid", 32'(o24_valid), 32'd0);
    chk("rst_sum",   32'(o24_sum),   32'd0);
    chk("rst_ovf",   32'(o24_ovf),   32'd0);
    chk("rst_inrdy", 32'(rdy24),     32'd1);

    // Table: groups with the sink always ready (includes saturation on AW=17)
    foreach (tbl[i]) run_group(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: result held, extra beat stalls until the handshake
    out_ready = 1'b0;
    run_group(tbl[4], "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(o24_valid), 32'd1);
      chk("bp_hold_sum",   32'(o24_sum),   32'd4);
      chk("bp_hold_inrdy", 32'(rdy24),     32'd0);
    end
    in_valid = 1'b1; in_prod = 16'd9;
    @(negedge clk);
    chk("bp_stall_inrdy", 32'(rdy24), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_valid", 32'(o24_valid), 32'd0);
    chk("bp_after_inrdy", 32'(rdy24),     32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(16'd1);
    chk("bp_next_valid", 32'(o24_valid), 32'd1);
    chk("bp_next_sum",   32'(o24_sum),   32'd12);
    @(negedge clk);

    // Clear mid-accumulation drops partial sum and the coincident beat
    send_beat(16'd10);
    send_beat(16'd20);
    clear = 1'b1; in_valid = 1'b1; in_prod = 16'd50;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid", 32'(o24_valid), 32'd0);
    run_group(mk(16'd1, 16'd2, 16'd3, 16'd4, 24'd10, 1'b0, 17'd10, 1'b0), "clr");

    // Clear while a result is pending discards it
    out_ready = 1'b0;
    run_group(tbl[0], "clrh");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrh_valid", 32'(o24_valid), 32'd0);
    chk("clrh_inrdy", 32'(rdy24),     32'd1);

    // Reset in HOLD
    run_group(tbl[0], "rsth");
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rsth_valid", 32'(o24_valid), 32'd0);
    chk("rsth_sum",   32'(o24_sum),   32'd0);
    chk("rsth_inrdy", 32'(rdy24),     32'd1);

    // Reset mid-accumulation leaves no partial sum behind
    out_ready = 1'b1;
    send_beat(16'd7);
    send_beat(16'd7);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_group(mk(16'd1, 16'd2, 16'd3, 16'd4, 24'd10, 1'b0, 17'd10, 1'b0), "rsta");

    // Gapped beats, random sink readiness, scoreboard
    macc = 0; mcnt = 0; idx = 0; results = 0; took = 1'b0;
    for (int c = 0; c < 2000 && results < 6; c++) begin
      @(negedge clk);
      if (took) begin
        in_valid = 1'b0;
        took = 1'b0;
      end else if (!in_valid && idx < 24 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_prod  = beats[idx % 8];
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && rdy24) begin
        macc += 32'(in_prod);
        mcnt++;
        idx++;
        took = 1'b1;
        if (mcnt == 4) begin
          q.push_back(macc);
          macc = 0;
          mcnt = 0;
        end
      end
      if (o24_valid && out_ready) begin
        if (q.size() > 0) expv = q.pop_front();
        else expv = 32'hDEAD_BEEF;
        chk("sb_sum24", 32'(o24_sum), expv);
        chk("sb_sum17", 32'(o17_sum), expv);
        results++;
      end
    end
    chk("sb_results", 32'(results), 32'd6);
    chk("sb_beats",   32'(idx),     32'd24);
    chk("sb_pending", 32'(q.size()), 32'd0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
